// File: rtl/alu_frame_sequencer_if.sv
// Bus bundle between the ALU frame sequencer and its surroundings.
//   in_*    : byte stream into the sequencer (valid/ready)
//   alu_*   : operand/op drive to the ALU and its result back
//   out_*   : captured result stream out of the sequencer (valid/ready)
// Modports:
//   master : the sequencer side (drives in_ready, alu_a/b/op, out_*)
//   slave  : the environment side (drives in_data/in_valid, alu_result, out_ready)
interface alu_frame_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RES_W  = 16,
  parameter int unsigned OP_W   = 6
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [RES_W-1:0]  alu_result;
  logic [RES_W-1:0]  out_result;
  logic [DATA_W-1:0] out_opcode;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  in_data, in_valid, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_result, out_opcode, out_valid
  );

  modport slave (
    output in_data, in_valid, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_result, out_opcode, out_valid
  );
endinterface

// File: rtl/alu_frame_sequencer.sv
// Byte-stream front end for the 8-bit ALU. Collects 3-byte frames
// (opcode, A, B), drives the ALU, waits ALU_LATENCY edges, captures the
// result and offers it downstream until accepted.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   bus        : alu_frame_sequencer_if.master (input stream, ALU drive, output stream)
//   bad_opcode : one-cycle pulse after an illegal opcode byte is consumed
//   busy       : high whenever a frame is in progress
//   err_count  : saturating illegal-opcode count (only with SEQ_ERR_COUNT_EN defined)
// Optional feature macro: SEQ_ERR_COUNT_EN.
module alu_frame_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RES_W       = 16,
  parameter int unsigned OP_W        = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  alu_frame_sequencer_if.master        bus,
  output logic                         bad_opcode,
  output logic                         busy
`ifdef SEQ_ERR_COUNT_EN
  ,
  output logic [7:0]                   err_count
`endif
);

  typedef enum logic [2:0] {StOpc, StA, StB, StExec, StOut} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opc_q;       // raw opcode of the frame in flight
  logic [OP_W-1:0]   op_q;        // decoded op waiting for the B byte
  logic [DATA_W-1:0] a_q;         // operand A waiting for the B byte
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [RES_W-1:0]  out_result_q;
  logic [DATA_W-1:0] out_opcode_q;
  logic [3:0]        cnt_q;
  logic              bad_q;

  logic              accept;
  logic              opc_legal;
  logic [OP_W-1:0]   opc_dec;
  logic              last_edge;

  assign accept    = bus.in_valid && bus.in_ready;
  // cnt_q is cleared on the B accept edge, so the capture edge is the
  // one on which it still reads ALU_LATENCY-1.
  assign last_edge = (cnt_q == 4'(ALU_LATENCY - 1));

  always_comb begin
    opc_legal = 1'b1;
    opc_dec   = '0;
    case (bus.in_data)
      DATA_W'(8'h00): opc_dec = OP_W'(0);
      DATA_W'(8'h01): opc_dec = OP_W'(1);
      DATA_W'(8'h02): opc_dec = OP_W'(2);
      DATA_W'(8'h03): opc_dec = OP_W'(3);
      DATA_W'(8'h04): opc_dec = OP_W'(4);
      DATA_W'(8'h08): opc_dec = OP_W'(8);
      default:        opc_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StOpc;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOpc:   if (accept && opc_legal) state_d = StA;
      StA:     if (accept)              state_d = StB;
      StB:     if (accept)              state_d = StExec;
      StExec:  if (last_edge)           state_d = StOut;
      StOut:   if (bus.out_ready)       state_d = StOpc;
      default:                          state_d = StOpc;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == StOpc) || (state_q == StA) || (state_q == StB);
    bus.out_valid = (state_q == StOut);
    busy          = (state_q != StOpc);
    bad_opcode    = bad_q;
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.out_result = out_result_q;
  assign bus.out_opcode = out_opcode_q;

  // Frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      out_result_q <= '0;
      out_opcode_q <= '0;
      cnt_q        <= '0;
      bad_q        <= 1'b0;
    end else begin
      bad_q <= accept && (state_q == StOpc) && !opc_legal;
      case (state_q)
        StOpc: begin
          if (accept && opc_legal) begin
            opc_q <= bus.in_data;
            op_q  <= opc_dec;
          end
        end
        StA: begin
          if (accept) a_q <= bus.in_data;
        end
        StB: begin
          // All three ALU inputs change together so the ALU never sees a mixed frame.
          if (accept) begin
            alu_a_q  <= a_q;
            alu_b_q  <= bus.in_data;
            alu_op_q <= op_q;
            cnt_q    <= '0;
          end
        end
        StExec: begin
          cnt_q <= cnt_q + 4'd1;
          if (last_edge) begin
            out_result_q <= bus.alu_result;
            out_opcode_q <= opc_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && (state_q == StOpc) && !opc_legal && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_frame_sequencer.sv
module tb_alu_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_frame_sequencer_if #(.DATA_W(8), .RES_W(16), .OP_W(6)) if1 ();
  alu_frame_sequencer_if #(.DATA_W(8), .RES_W(16), .OP_W(6)) if4 ();

  logic bad1, bad4, busy1, busy4;
`ifdef SEQ_ERR_COUNT_EN
  logic [7:0] ec1, ec4;
`endif

  alu_frame_sequencer #(.ALU_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .bad_opcode(bad1), .busy(busy1)
`ifdef SEQ_ERR_COUNT_EN
    , .err_count(ec1)
`endif
  );

  alu_frame_sequencer #(.ALU_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .bad_opcode(bad4), .busy(busy4)
`ifdef SEQ_ERR_COUNT_EN
    , .err_count(ec4)
`endif
  );

  // ALU stub
  assign if1.alu_result = {if1.alu_a, if1.alu_b} + {10'd0, if1.alu_op};
  assign if4.alu_result = {if4.alu_a, if4.alu_b} + {10'd0, if4.alu_op};

  // Shared stimulus, steered to one DUT by sel
  logic       sel = 1'b0;
  logic [7:0] tb_data = 8'h00;
  logic       tb_valid = 1'b0;
  logic       tb_out_ready = 1'b0;

  assign if1.in_data   = tb_data;
  assign if4.in_data   = tb_data;
  assign if1.in_valid  = tb_valid & ~sel;
  assign if4.in_valid  = tb_valid & sel;
  assign if1.out_ready = tb_out_ready;
  assign if4.out_ready = tb_out_ready;

  wire        cur_in_ready  = sel ? if4.in_ready   : if1.in_ready;
  wire        cur_out_valid = sel ? if4.out_valid  : if1.out_valid;
  wire [15:0] cur_out_res   = sel ? if4.out_result : if1.out_result;
  wire [7:0]  cur_out_opc   = sel ? if4.out_opcode : if1.out_opcode;
  wire [7:0]  cur_alu_a     = sel ? if4.alu_a      : if1.alu_a;
  wire [7:0]  cur_alu_b     = sel ? if4.alu_b      : if1.alu_b;
  wire [5:0]  cur_alu_op    = sel ? if4.alu_op     : if1.alu_op;
  wire        cur_bad       = sel ? bad4           : bad1;
  wire        cur_busy      = sel ? busy4          : busy1;
`ifdef SEQ_ERR_COUNT_EN
  wire [7:0]  cur_ec        = sel ? ec4            : ec1;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state, per DUT
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic [5:0] m_op [2];
  int         m_err [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] o);
    return o inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08};
  endfunction

  function automatic logic [5:0] op_of(input logic [7:0] o);
    case (o)
      8'h01:   return 6'd1;
      8'h02:   return 6'd2;
      8'h03:   return 6'd3;
      8'h04:   return 6'd4;
      8'h08:   return 6'd8;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [15:0] ref_result(input logic [7:0] o, input logic [7:0] a,
                                             input logic [7:0] b);
    int unsigned s;
    s = (int'(a) * 256 + int'(b) + int'(op_of(o))) % 65536;
    return 16'(s);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = 8'h00; m_b[i] = 8'h00; m_op[i] = 6'd0; m_err[i] = 0;
    end
  endtask

  // Starts and ends just after a falling edge
  task automatic send_byte(input logic [7:0] d);
    int w;
    tb_data  = d;
    tb_valid = 1'b1;
    w = 0;
    while (!cur_in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!cur_in_ready) chk("in_ready_timeout", 32'(cur_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
  endtask

  task automatic check_alu_hold(input logic s);
    chk("alu_a_hold",  32'(cur_alu_a),  32'(m_a[s]));
    chk("alu_b_hold",  32'(cur_alu_b),  32'(m_b[s]));
    chk("alu_op_hold", 32'(cur_alu_op), 32'(m_op[s]));
  endtask

  task automatic run_frame(input logic s, input logic [7:0] o, input logic [7:0] a,
                           input logic [7:0] b, input int hold, input logic exp_bad,
                           input logic [15:0] exp_res);
    int lat;
    sel = s;
    tb_out_ready = (hold == 0);
    send_byte(o);
    if (exp_bad) begin
      if (m_err[s] < 255) m_err[s]++;
      chk("bad_pulse", 32'(cur_bad), 32'd1);
      chk("bad_in_ready", 32'(cur_in_ready), 32'd1);
      chk("bad_busy", 32'(cur_busy), 32'd0);
      check_alu_hold(s);
      @(negedge clk);
      chk("bad_once", 32'(cur_bad), 32'd0);
`ifdef SEQ_ERR_COUNT_EN
      chk("err_count", 32'(cur_ec), 32'(m_err[s]));
`endif
    end else begin
      chk("busy_a", 32'(cur_busy), 32'd1);
      check_alu_hold(s);
      send_byte(a);
      check_alu_hold(s);
      send_byte(b);
      m_a[s] = a; m_b[s] = b; m_op[s] = op_of(o);
      check_alu_hold(s);
      // Junk offered while busy must be ignored
      tb_data  = 8'h05;
      tb_valid = 1'b1;
      lat = 0;
      while (!cur_out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", 32'(lat), s ? 32'd4 : 32'd1);
      chk("out_result", 32'(cur_out_res), 32'(exp_res));
      chk("out_opcode", 32'(cur_out_opc), 32'(o));
      chk("exec_in_ready", 32'(cur_in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(cur_out_valid), 32'd1);
        chk("hold_result", 32'(cur_out_res), 32'(exp_res));
        chk("hold_in_ready", 32'(cur_in_ready), 32'd0);
      end
      tb_valid = 1'b0;
      tb_out_ready = 1'b1;
      @(negedge clk);
      chk("done_valid", 32'(cur_out_valid), 32'd0);
      chk("done_in_ready", 32'(cur_in_ready), 32'd1);
      chk("done_busy", 32'(cur_busy), 32'd0);
      chk("no_bad", 32'(cur_bad), 32'd0);
      check_alu_hold(s);
    end
  endtask

  typedef struct {
    logic       s;
    logic [7:0] o, a, b;
    int         hold;
    logic       bad;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] o, a, b;
    logic       s;
    int         h;

    vecs[0] = '{1'b0, 8'h02, 8'h12, 8'h34, 0, 1'b0, 16'h1236};
    vecs[1] = '{1'b0, 8'h08, 8'hFF, 8'hFF, 5, 1'b0, 16'h0007};
    vecs[2] = '{1'b0, 8'h05, 8'h00, 8'h00, 0, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 8'h00, 8'h01, 8'h01, 0, 1'b0, 16'h0101};
    vecs[4] = '{1'b0, 8'h03, 8'h0A, 8'h0B, 1, 1'b0, 16'h0A0E};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'h00, 0, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 8'h04, 8'h01, 8'h00, 0, 1'b0, 16'h0104};
    vecs[7] = '{1'b1, 8'h04, 8'h80, 8'h01, 2, 1'b0, 16'h8005};

    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(if1.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_bad", 32'(bad1), 32'd0);
    chk("rst_alu", {8'h00, if1.alu_a, if1.alu_b, 2'b00, if1.alu_op}, 32'd0);
    chk("rst_out_result", 32'(if1.out_result), 32'd0);
    chk("rst_in_ready4", 32'(if4.in_ready), 32'd1);
    chk("rst_busy4", 32'(busy4), 32'd0);

    foreach (vecs[i])
      run_frame(vecs[i].s, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].bad,
                vecs[i].res);

    // Reset mid-frame aborts everything
    sel = 1'b0;
    tb_out_ready = 1'b1;
    send_byte(8'h03);
    send_byte(8'h10);
    chk("mid_busy_pre", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy1), 32'd0);
    chk("mid_in_ready", 32'(if1.in_ready), 32'd1);
    chk("mid_out_valid", 32'(if1.out_valid), 32'd0);
    chk("mid_alu_a", 32'(if1.alu_a), 32'd0);
    chk("mid_alu_a4", 32'(if4.alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    run_frame(1'b0, 8'h01, 8'h00, 8'h02, 0, 1'b0, 16'h0003);

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        do o = 8'($urandom); while (is_legal(o));
      end else begin
        case ($urandom_range(0, 5))
          0: o = 8'h00;
          1: o = 8'h01;
          2: o = 8'h02;
          3: o = 8'h03;
          4: o = 8'h04;
          default: o = 8'h08;
        endcase
      end
      a = 8'($urandom);
      b = 8'($urandom);
      h = int'($urandom_range(0, 2));
      run_frame(s, o, a, b, h, !is_legal(o), ref_result(o, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_frame_sequencer.md
Name: alu_frame_sequencer

Overview:
Byte-stream front end for the 8-bit ALU. It accepts a serial stream of 3-byte frames (opcode, operand A, operand B) over a valid/ready handshake and decodes the opcode into the ALU's 6-bit op code. It drives the ALU's a/b/op inputs, waits a fixed ALU latency, then captures the 16-bit result. It presents the result downstream over a second valid/ready handshake. This is the hardware replacement for file-driven operand feeding of the ALU.

Parameters:
ALU_LATENCY, 1, number of clock edges from alu_* update to sampling alu_result; legal range 1..15
DATA_W, 8, width of the input stream byte, alu_a and alu_b
RES_W, 16, width of alu_result and out_result
OP_W, 6, width of alu_op

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  stream byte (opcode, A or B depending on state)
in_valid  input  1  in_data valid
in_ready  output  1  sequencer can accept a byte
alu_a  output  DATA_W  registered operand A to the ALU
alu_b  output  DATA_W  registered operand B to the ALU
alu_op  output  OP_W  registered decoded op to the ALU
alu_result  input  RES_W  ALU result (combinational or pipelined per ALU_LATENCY)
out_result  output  RES_W  captured result
out_opcode  output  DATA_W  raw opcode byte of the frame that produced out_result
out_valid  output  1  out_result/out_opcode valid
out_ready  input  1  downstream accepts the result
bad_opcode  output  1  one-cycle pulse: illegal opcode byte consumed
busy  output  1  high in any state other than S_OPC

Behaviour:
- States: S_OPC, S_A, S_B, S_EXEC, S_OUT. Reset state is S_OPC.
- Reset values: all registers 0. in_ready=1 (S_OPC). out_valid=0, bad_opcode=0, busy=0.
- in_ready = 1 in S_OPC/S_A/S_B, else 0. A byte is accepted only on an edge where in_valid && in_ready.
- Opcode decode (byte -> alu_op): 0x00->0, 0x01->1, 0x02->2, 0x03->3, 0x04->4, 0x08->8. All other bytes are illegal.
- S_OPC, legal opcode accepted: latch opcode and decoded op (pending), go to S_A.
- S_OPC, illegal opcode accepted: discard the byte, pulse bad_opcode for exactly the next cycle, stay in S_OPC. No frame starts and alu_* are unchanged.
- S_A: accepted byte is latched as pending A; go to S_B.
- S_B: on accept, load alu_a, alu_b and alu_op simultaneously on that same edge, clear the latency counter, go to S_EXEC. alu_* never change mid-frame.
- S_EXEC: the counter increments each edge. On the ALU_LATENCY-th edge after the B accept edge:
  - out_result <= alu_result
  - out_opcode <= frame opcode
  - out_valid <= 1
  - go to S_OUT
  - With ALU_LATENCY=1, out_valid is high in the cycle after the B accept cycle +1 edge.
- S_OUT: out_valid, out_result and out_opcode are held stable until out_valid && out_ready. On that edge, out_valid <= 0 and go to S_OPC. in_ready is 1 the following cycle. There is no frame overlap.
- alu_a/b/op hold their last values after a frame completes. They are not cleared.
- in_valid is ignored while in_ready=0. No byte is lost or consumed in S_EXEC/S_OUT.
- Reset asserted mid-frame: immediate abort. The partial frame is discarded, all outputs return to reset values, and the state returns to S_OPC.
- Minimum frame period: 3 accept cycles + ALU_LATENCY + 1 output cycle.

Optional Feature:
Macro SEQ_ERR_COUNT_EN.
- Defined: adds output port err_count [7:0]. It increments on every illegal opcode accept and saturates at 0xFF. It resets to 0 on rst_n only.
- Undefined: the port and counter are absent. bad_opcode pulses are unaffected.

Test Plan:
Bench ALU stub: alu_result = {alu_a, alu_b} + alu_op.
- Reset then idle: in_ready=1, out_valid=0, busy=0, alu_*=0, bad_opcode=0.
- Frame 0x02,0x12,0x34, out_ready=1, ALU_LATENCY=1 -> alu_op=2, alu_a=0x12, alu_b=0x34; out_result=0x1236, out_opcode=0x02; out_valid high exactly one cycle.
- Frame 0x08,0xFF,0xFF with out_ready=0 for 5 cycles -> out_result=0x0007 (wrap) held stable, in_ready=0 throughout. Releasing out_ready -> return to S_OPC next cycle.
- Byte 0x05 then frame 0x00,0x01,0x01 -> bad_opcode pulses once; frame yields out_result=0x0101, out_opcode=0x00. With SEQ_ERR_COUNT_EN, err_count=1.
- rst_n low after opcode 0x03 and A=0x10 -> busy=0, in_ready=1. Next frame 0x01,0x00,0x02 gives out_result=0x0003.
- ALU_LATENCY=4, frame 0x04,0x01,0x00 -> out_valid rises 4 edges after the B accept edge; out_result=0x0104.
